// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// traffic onto a single synchronous-read byte RAM, with IO-store backpressure.
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_en,
    input  logic [31:0] if_pc,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_en,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR,
        COOL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   nbytes_q, nbytes_d;
    logic [AW-1:0]   base_q, base_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   asm_q, asm_d;
    logic            io_q, io_d;
    logic            last_lsb_q, last_lsb_d;
    logic            frozen_q, frozen_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   mem_a_d;
    logic [7:0]      mem_dout_d;
    logic            if_done_d, lsb_done_d;
    logic [DW-1:0]   if_data_d, lsb_rdata_d;
    logic [CW-1:0]   nxt;
    logic [1:0]      rd_idx;
    logic            acc_io;

    function automatic logic [CW-1:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return CW'(1);
            2'd1:    return CW'(2);
            default: return CW'(4);
        endcase
    endfunction

    assign mem_wr = wr_q & rdy;

    // Next-state and datapath update; done pulses clear every cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        io_d        = io_q;
        last_lsb_d  = last_lsb_q;
        frozen_d    = frozen_q;
        wr_d        = wr_q;
        mem_a_d     = mem_a;
        mem_dout_d  = mem_dout;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if_data_d   = if_data;
        lsb_rdata_d = lsb_rdata;
        nxt         = '0;
        rd_idx      = '0;
        acc_io      = (lsb_addr[17:16] == IO_SEL);

        if (!rdy) begin
            frozen_d = 1'b1;
        end else begin
            frozen_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!clear) begin
                        if (if_en && (!lsb_en || last_lsb_q)) begin
                            state_d    = IF_RD;
                            last_lsb_d = 1'b0;
                            base_d     = if_pc;
                            nbytes_d   = CW'(4);
                            mem_a_d    = if_pc;
                            cnt_d      = '0;
                            asm_d      = '0;
                        end else if (lsb_en) begin
                            last_lsb_d = 1'b1;
                            base_d     = lsb_addr;
                            nbytes_d   = len_bytes(lsb_len);
                            wdata_d    = lsb_wdata;
                            io_d       = acc_io;
                            mem_a_d    = lsb_addr;
                            cnt_d      = '0;
                            asm_d      = '0;
                            if (lsb_wr) begin
                                state_d = LS_WR;
                                if (acc_io && io_buffer_full) begin
                                    wr_d = 1'b0;
                                end else begin
                                    wr_d       = 1'b1;
                                    mem_dout_d = lsb_wdata[7:0];
                                end
                            end else begin
                                state_d = LS_RD;
                            end
                        end
                    end
                end
                IF_RD, LS_RD: begin
                    rd_idx = 2'(cnt_q - 3'd1);
                    if (clear) begin
                        state_d = IDLE;
                        wr_d    = 1'b0;
                    end else if (frozen_q) begin
                        // RAM data in flight is stale after a freeze; start over.
                        mem_a_d = base_q;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q != '0) begin
                            asm_d[{rd_idx, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q == nbytes_q) begin
                            state_d = COOL;
                            if (state_q == IF_RD) begin
                                if_done_d = 1'b1;
                                if_data_d = asm_d;
                            end else begin
                                lsb_done_d  = 1'b1;
                                lsb_rdata_d = asm_d;
                            end
                        end else begin
                            if (cnt_q + 3'd1 < nbytes_q) begin
                                mem_a_d = base_q + AW'(cnt_q + 3'd1);
                            end
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                LS_WR: begin
                    // cnt is the byte on the bus; it is finished only if the strobe was set.
                    nxt = cnt_q + CW'(wr_q);
                    if (nxt == nbytes_q) begin
                        wr_d       = 1'b0;
                        lsb_done_d = 1'b1;
                        state_d    = COOL;
                    end else if (io_q && io_buffer_full) begin
                        wr_d  = 1'b0;
                        cnt_d = nxt;
                    end else begin
                        wr_d       = 1'b1;
                        cnt_d      = nxt;
                        mem_a_d    = base_q + AW'(nxt);
                        mem_dout_d = wdata_q[{2'(nxt), 3'b000} +: 8];
                    end
                end
                COOL: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nbytes_q   <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            io_q       <= 1'b0;
            last_lsb_q <= 1'b1;
            frozen_q   <= 1'b0;
            wr_q       <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= '0;
            if_done    <= 1'b0;
            lsb_done   <= 1'b0;
            if_data    <= '0;
            lsb_rdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            io_q       <= io_d;
            last_lsb_q <= last_lsb_d;
            frozen_q   <= frozen_d;
            wr_q       <= wr_d;
            mem_a      <= mem_a_d;
            mem_dout   <= mem_dout_d;
            if_done    <= if_done_d;
            lsb_done   <= lsb_done_d;
            if_data    <= if_data_d;
            lsb_rdata  <= lsb_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM model, directed vector table,
// multi-cycle corner sequences and randomized traffic against a byte-array model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_en, if_done;
    logic [31:0] if_pc, if_data;
    logic        lsb_en, lsb_wr, lsb_done;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_len;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    logic        tb_init, tb_we;
    logic [15:0] tb_wa;
    logic [7:0]  tb_wd;

    logic [7:0]  ram     [0:65535];
    logic [7:0]  exp_ram [0:65535];

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int unsigned cyc;
    } wr_t;
    wr_t wlog[$];
    int unsigned cyc = 0;

    typedef struct {
        int          op;     // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[12];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Synchronous-read byte RAM; every DUT write is logged with its cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tb_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
        end else if (tb_we) begin
            ram[tb_wa] <= tb_wd;
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wlog.push_back('{a: mem_a, d: mem_dout, cyc: cyc});
        end
        mem_din <= ram[mem_a[15:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = exp_ram[16'(addr + 32'(i))];
        return r;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        exp_ram[a] = d;
    endtask

    task automatic rand_env();
        rdy = ($urandom_range(0, 15) != 0);
        io_buffer_full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic run_req(input int op, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata, input bit rnd,
                           output logic [31:0] data, output int lat);
        @(negedge clk);
        wlog.delete();
        if (op == 0) begin
            if_en = 1'b1; if_pc = addr;
        end else begin
            lsb_en = 1'b1; lsb_wr = (op == 2); lsb_addr = addr;
            lsb_len = len; lsb_wdata = wdata;
        end
        if (rnd) rand_env();
        lat = -1;
        data = '0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if ((op == 0) ? if_done : lsb_done) begin
                lat = c;
                data = (op == 0) ? if_data : lsb_rdata;
                break;
            end
            if (rnd) rand_env();
        end
        if_en = 1'b0;
        lsb_en = 1'b0;
        if (op == 2 && lat > 0)
            for (int i = 0; i < nb(len); i++) exp_ram[16'(addr + 32'(i))] = 8'(wdata >> (8 * i));
    endtask

    task automatic check_store(input string tag, input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] wdata, input bit consec);
        int n = nb(len);
        chk({tag, "_nwr"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            chk({tag, "_wa"}, wlog[i].a, addr + 32'(i));
            chk({tag, "_wd"}, 32'(wlog[i].d), (wdata >> (8 * i)) & 32'hFF);
            if (consec && i > 0) chk({tag, "_wcyc"}, wlog[i].cyc - wlog[i-1].cyc, 32'd1);
        end
    endtask

    task automatic tie_test(input string tag);
        int fd = -1, ld = -1;
        logic [31:0] fdat = '0, ldat = '0;
        @(negedge clk);
        wlog.delete();
        if_en = 1'b1; if_pc = 32'h1000;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2002; lsb_len = 2'd1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (if_done) begin fd = c; fdat = if_data; if_en = 1'b0; end
            if (lsb_done) begin ld = c; ldat = lsb_rdata; break; end
        end
        if_en = 1'b0;
        lsb_en = 1'b0;
        chk({tag, "_fetch_lat"}, 32'(fd), 32'd6);
        chk({tag, "_fetch_data"}, fdat, 32'h0000_0513);
        chk({tag, "_load_lat"}, 32'(ld), 32'd11);
        chk({tag, "_load_data"}, ldat, 32'h0000_BBAA);
        chk({tag, "_no_write"}, 32'(wlog.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] data;
        int lat, cnt, lat2;
        bit flag;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        if_en = 1'b0; if_pc = '0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        tb_init = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        for (int i = 0; i < 65536; i++) exp_ram[i] = pat(i);

        vecs[0]  = '{0, 32'h0000_1000, 2'd0, 32'h0,         32'h0000_0513, 6};
        vecs[1]  = '{1, 32'h0000_2002, 2'd0, 32'h0,         32'h0000_00AA, 3};
        vecs[2]  = '{1, 32'h0000_2002, 2'd1, 32'h0,         32'h0000_BBAA, 4};
        vecs[3]  = '{1, 32'h0000_2000, 2'd3, 32'h0,         32'hBBAA_2211, 6};
        vecs[4]  = '{2, 32'h0000_5000, 2'd2, 32'h1234_5678, 32'h0,         5};
        vecs[5]  = '{1, 32'h0000_5000, 2'd2, 32'h0,         32'h1234_5678, 6};
        vecs[6]  = '{2, 32'h0000_5004, 2'd0, 32'hFFFF_FF99, 32'h0,         2};
        vecs[7]  = '{1, 32'h0000_5004, 2'd2, 32'h0,         32'h0000_0099, 6};
        vecs[8]  = '{2, 32'hFFFF_FFFF, 2'd1, 32'h0000_CDAB, 32'h0,         3};
        vecs[9]  = '{1, 32'hFFFF_FFFF, 2'd1, 32'h0,         32'h0000_CDAB, 4};
        vecs[10] = '{2, 32'h0000_3000, 2'd2, 32'hDEAD_BEEF, 32'h0,         5};
        vecs[11] = '{0, 32'h0000_3000, 2'd0, 32'h0,         32'hDEAD_BEEF, 6};

        repeat (2) @(negedge clk);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_lsb_done", 32'(lsb_done), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        tb_init = 1'b0;
        rst = 1'b0;

        poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
        poke(16'h2000, 8'h11); poke(16'h2001, 8'h22); poke(16'h2002, 8'hAA); poke(16'h2003, 8'hBB);
        poke(16'h4000, 8'h01); poke(16'h4001, 8'h02); poke(16'h4002, 8'h03); poke(16'h4003, 8'h04);
        poke(16'h5005, 8'h00); poke(16'h5006, 8'h00); poke(16'h5007, 8'h00);
        @(negedge clk);
        tb_we = 1'b0;

        tie_test("tie");

        foreach (vecs[k]) begin
            run_req(vecs[k].op, vecs[k].addr, vecs[k].len, vecs[k].wdata, 1'b0, data, lat);
            chk($sformatf("vec%0d_lat", k), 32'(lat), 32'(vecs[k].lat));
            if (vecs[k].op == 2) begin
                check_store($sformatf("vec%0d", k), vecs[k].addr, vecs[k].len, vecs[k].wdata, 1'b1);
            end else begin
                chk($sformatf("vec%0d_data", k), data, vecs[k].exp);
                chk($sformatf("vec%0d_no_write", k), 32'(wlog.size()), 32'd0);
            end
        end

        // IO store stalled by a full output buffer for 5 cycles.
        @(negedge clk);
        wlog.delete();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_len = 2'd0; lsb_wdata = 32'h41;
        io_buffer_full = 1'b1;
        flag = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (lsb_done) flag = 1'b1;
        end
        chk("io_stall_no_write", 32'(wlog.size()), 32'd0);
        chk("io_stall_no_done", 32'(flag), 32'd0);
        io_buffer_full = 1'b0;
        lat = -1;
        for (int c = 6; c <= 30; c++) begin
            @(negedge clk);
            if (lsb_done) begin lat = c; break; end
        end
        lsb_en = 1'b0;
        chk("io_done_lat", 32'(lat), 32'd7);
        check_store("io", 32'h0003_0000, 2'd0, 32'h41, 1'b0);
        exp_ram[16'h0000] = 8'h41;

        // Clear in the 3rd fetch cycle aborts; the next fetch is taken right away.
        @(negedge clk);
        if_en = 1'b1; if_pc = 32'h2000;
        cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (if_done) cnt++;
        end
        clear = 1'b1; if_en = 1'b0;
        @(negedge clk);
        if (if_done) cnt++;
        chk("clr_if_data_held", if_data, 32'hDEAD_BEEF);
        clear = 1'b0; if_en = 1'b1; if_pc = 32'h1000;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (if_done) begin lat = c; data = if_data; break; end
        end
        if_en = 1'b0;
        chk("clr_no_done", 32'(cnt), 32'd0);
        chk("clr_refetch_lat", 32'(lat), 32'd6);
        chk("clr_refetch_data", data, 32'h0000_0513);

        // Clear during a store does not stop it.
        @(negedge clk);
        wlog.delete();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h5010; lsb_len = 2'd1; lsb_wdata = 32'h7788;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lsb_done) begin lat = c; break; end
            clear = (c == 1);
        end
        clear = 1'b0; lsb_en = 1'b0;
        chk("st_clr_lat", 32'(lat), 32'd3);
        check_store("st_clr", 32'h5010, 2'd1, 32'h7788, 1'b1);
        exp_ram[16'h5010] = 8'h88; exp_ram[16'h5011] = 8'h77;

        // rdy low for 3 cycles mid-load: the read restarts once rdy returns in cycle 5.
        @(negedge clk);
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h4000; lsb_len = 2'd2;
        lat = -1; flag = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (lsb_done) begin
                lat = c; data = lsb_rdata;
                if (!rdy) flag = 1'b1;
                break;
            end
            if (c == 2) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
        end
        lsb_en = 1'b0; rdy = 1'b1;
        chk("rdy_load_lat", 32'(lat), 32'd11);
        chk("rdy_load_data", data, 32'h0403_0201);
        chk("rdy_no_done_low", 32'(flag), 32'd0);

        // Reset in mid-fetch: no done, outputs cleared, tie goes back to fetch.
        @(negedge clk);
        if_en = 1'b1; if_pc = 32'h1000;
        repeat (2) @(negedge clk);
        rst = 1'b1; if_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_mem_a", mem_a, 32'd0);
        chk("mrst_if_data", if_data, 32'd0);
        cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (if_done) cnt++;
        end
        chk("mrst_no_done", 32'(cnt), 32'd0);
        tie_test("tie2");

        // Randomized traffic with random rdy and IO backpressure.
        for (int t = 0; t < 150; t++) begin
            int op;
            logic [31:0] addr, wdata, expd;
            logic [1:0] len;
            op = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       addr = 32'h0000_6000 + 32'($urandom_range(0, 63));
                1:       addr = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
                default: addr = 32'h0003_0000 + 32'($urandom_range(0, 63));
            endcase
            if (op == 0) addr = addr & 32'hFFFF_FFFC;
            len = 2'($urandom_range(0, 3));
            wdata = $urandom;
            expd = exp_read(addr, (op == 0) ? 4 : nb(len));
            run_req(op, addr, len, wdata, 1'b1, data, lat2);
            chk($sformatf("rnd%0d_completes", t), 32'(lat2 > 0), 32'd1);
            if (lat2 > 0) begin
                if (op == 2) begin
                    check_store($sformatf("rnd%0d", t), addr, len, wdata, 1'b0);
                end else begin
                    chk($sformatf("rnd%0d_data", t), data, expd);
                    chk($sformatf("rnd%0d_no_write", t), 32'(wlog.size()), 32'd0);
                end
            end
        end
        rdy = 1'b1;
        io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 IO_SEL, default 2'b11: address bits [17:16] equal to this value mark an IO address.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 rdy  in  1  global enable; low freezes the block.
REQ-005 clear  in  1  pipeline flush from the reorder buffer.
REQ-006 if_en  in  1  fetch request; held high until if_done.
REQ-007 if_pc  in  32  fetch address, word-aligned.
REQ-008 if_done  out  1  one-cycle pulse; if_data valid.
REQ-009 if_data  out  32  fetched word, little-endian.
REQ-010 lsb_en  in  1  load/store request; held high until lsb_done.
REQ-011 lsb_wr  in  1  1 = store, 0 = load.
REQ-012 lsb_addr  in  32  byte address.
REQ-013 lsb_len  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal.
REQ-014 lsb_wdata  in  32  store data; low bytes used.
REQ-015 lsb_done  out  1  one-cycle pulse on completion.
REQ-016 lsb_rdata  out  32  load data, zero-extended, little-endian.
REQ-017 mem_din  in  8  RAM read byte.
REQ-018 mem_dout  out  8  RAM write byte.
REQ-019 mem_a  out  32  RAM byte address.
REQ-020 mem_wr  out  1  RAM write strobe; 1 = write.
REQ-021 io_buffer_full  in  1  IO output buffer full.

Function
REQ-022 States: IDLE, IF_RD, LS_RD, LS_WR, COOL.
REQ-023 mem_a, mem_dout and the internal write strobe are registered; mem_wr = write strobe AND rdy.
REQ-024 Requests are sampled only in IDLE and only when clear is low.
REQ-025 In IDLE with one request pending: accept it; with both pending: accept the requester not served last (round-robin); the last-served flag updates on acceptance.
REQ-026 Acceptance edge E0: mem_a <= start address; byte counter <= 0; target state entered.
REQ-027 Read of N bytes (fetch N = 4; load N = 1/2/4):
- mem_a = addr + i during the cycle after edge Ei, for i < N.
- mem_din is sampled at edge E(i+2) into byte i of the assembly register.
- At edge E(N+1), the done pulse goes high for exactly one cycle with data valid, and the state goes to COOL.
- Fetch latency: done is high in the 6th cycle after the acceptance cycle.
REQ-028 Store of N bytes:
- Edge Ei (i < N): mem_a <= addr + i, mem_dout <= lsb_wdata byte i, write strobe <= 1.
- Edge EN: write strobe <= 0, lsb_done pulse, state goes to COOL.
REQ-029 Store to an IO address (lsb_addr[17:16] == IO_SEL): no byte is issued while io_buffer_full is high; the strobe is held at 0 and the counter holds until it drops.
REQ-030 COOL lasts exactly one cycle, then IDLE; this prevents re-accepting a request that is still asserted in the done cycle.
REQ-031 if_data and lsb_rdata hold their value until the next completion of the same type; lsb_rdata bytes above N are 0.
REQ-032 clear high during IF_RD or LS_RD: abort at that edge; go to IDLE; no done pulse; write strobe 0.
REQ-033 clear during LS_WR: ignored; the store completes and lsb_done pulses (committed store).
REQ-034 clear in IDLE or COOL: no acceptance that cycle.
REQ-035 rdy low: all registers hold and mem_wr is 0. When rdy returns, an in-progress read restarts from byte 0 at the same address; an in-progress write resumes at the current byte.
REQ-036 Address arithmetic is 32-bit with wrap-around at 2^32.
REQ-037 lsb_len = 3 is treated as a 4-byte access.

Reset
REQ-038 On rst: state IDLE; if_done = 0, lsb_done = 0, mem_wr = 0, mem_a = 0, mem_dout = 0, if_data = 0, lsb_rdata = 0, byte counter = 0; last-served flag = LSB, so the first tie goes to fetch.
REQ-039 rst mid-transaction: abandon it immediately; no done pulse is produced.

Verification
REQ-040 Fetch 0x1000, RAM bytes 13 05 00 00 -> if_done in the 6th cycle after acceptance, if_data = 0x00000513, mem_wr = 0 throughout.
REQ-041 if_en and lsb_en (load, len 2, addr 0x2002) raised in the same cycle after reset -> fetch served first, then the load; lsb_rdata = 0x0000BBAA for bytes AA BB; a COOL cycle separates the two.
REQ-042 Store len 4, 0xDEADBEEF to 0x3000 -> writes EF, BE, AD, DE to 0x3000..0x3003 on 4 consecutive cycles, then lsb_done.
REQ-043 IO store 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> no mem_wr during the stall; one write after release; lsb_done.
REQ-044 clear on the 3rd cycle of a fetch -> no if_done, state IDLE, a new if_en is accepted on the following cycle.
REQ-045 rdy low for 3 cycles mid-load -> correct lsb_rdata after resume; no done pulse while rdy is low.
